// File: rtl/dc_ipu_filter_phase_gen.sv
// Scaler filter phase generator: source index and phase per output pixel.
// Optional DC_IPU_PHASE_ROUND_EN rounds alpha to nearest instead of truncating.
module dc_ipu_filter_phase_gen #(
  parameter int WEIGHT_WIDTH       = 10,
  parameter int WEIGHT_FRACT_WIDTH = 8,
  parameter int COORD_WIDTH        = 12,
  parameter int STEP_FRACT_WIDTH   = 16
) (
  input  logic                                    clk,
  input  logic                                    nreset,
  input  logic                                    start,
  input  logic [COORD_WIDTH-1:0]                  out_len,
  input  logic [COORD_WIDTH-1:0]                  src_max,
  input  logic [COORD_WIDTH+STEP_FRACT_WIDTH-1:0] step,
  input  logic [COORD_WIDTH+STEP_FRACT_WIDTH-1:0] init_phase,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [WEIGHT_WIDTH-1:0]                 alpha,
  output logic [COORD_WIDTH-1:0]                  src_idx,
  output logic [COORD_WIDTH-1:0]                  src_adv,
  output logic                                    out_last,
  output logic                                    busy,
  output logic                                    done
);

  localparam int CW = COORD_WIDTH;
  localparam int SF = STEP_FRACT_WIDTH;
  localparam int WF = WEIGHT_FRACT_WIDTH;
  localparam int WW = WEIGHT_WIDTH;
  localparam int SW = CW + SF;
  localparam int AW = SW + 1;
  localparam int IW = AW + 1 - SF;
  localparam int RSH = (SF > WF) ? (SF - WF - 1) : 0;

`ifdef DC_IPU_PHASE_ROUND_EN
  localparam logic [AW:0] HALF =
    (SF > WF) ? ({{AW{1'b0}}, 1'b1} << RSH) : '0;
`else
  localparam logic [AW:0] HALF = '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] step_q, step_d;
  logic [CW-1:0] max_q, max_d;
  logic [WW-1:0] alpha_q, alpha_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] adv_q, adv_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          hs;
  logic [AW:0]   sum;
  logic [AW-1:0] acc_n;
  logic [AW-1:0] c_acc;
  logic [CW-1:0] c_max;
  logic [AW:0]   c_r;
  logic [IW-1:0] c_int;
  logic [CW-1:0] c_idx;
  logic [WW-1:0] c_alpha;

  assign hs = valid_q & out_ready;

  // Saturating accumulator advance
  always_comb begin
    sum   = {1'b0, acc_q} + {{(AW-SW+1){1'b0}}, step_q};
    acc_n = sum[AW] ? '1 : sum[AW-1:0];
  end

  // Index/phase from an accumulator value, rounded and clamped
  always_comb begin
    c_acc   = (state_q == S_IDLE) ? {1'b0, init_phase} : acc_n;
    c_max   = (state_q == S_IDLE) ? src_max : max_q;
    c_r     = {1'b0, c_acc} + HALF;
    c_int   = c_r[AW:SF];
    c_idx   = c_int[CW-1:0];
    c_alpha = {{(WW-WF){1'b0}}, c_r[SF-1 -: WF]};
    if (c_int > {2'b00, c_max}) begin
      c_idx   = c_max;
      c_alpha = '0;
    end
  end

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      step_q  <= '0;
      max_q   <= '0;
      alpha_q <= '0;
      idx_q   <= '0;
      adv_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      max_q   <= max_d;
      alpha_q <= alpha_d;
      idx_q   <= idx_d;
      adv_q   <= adv_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start)
          state_d = (out_len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (hs && last_q)
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    max_d   = max_q;
    alpha_d = alpha_q;
    idx_d   = idx_q;
    adv_d   = adv_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (state_q == S_IDLE && start && out_len != '0) begin
      acc_d   = {1'b0, init_phase};
      cnt_d   = out_len;
      step_d  = step;
      max_d   = src_max;
      idx_d   = c_idx;
      alpha_d = c_alpha;
      adv_d   = '0;
      valid_d = 1'b1;
      last_d  = (out_len == CW'(1));
    end else if (state_q == S_RUN && hs) begin
      acc_d = acc_n;
      cnt_d = cnt_q - CW'(1);
      if (last_q) begin
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        idx_d   = c_idx;
        alpha_d = c_alpha;
        adv_d   = c_idx - idx_q;
        last_d  = (cnt_q == CW'(2));
      end
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign out_valid = valid_q;
  assign alpha     = alpha_q;
  assign src_idx   = idx_q;
  assign src_adv   = adv_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dc_ipu_filter_phase_gen.sv
// Directed bench for dc_ipu_filter_phase_gen.
// Expected sequences are hand-computed for the default parameters.
module tb_dc_ipu_filter_phase_gen;

  logic        clk;
  logic        nreset;
  logic        start;
  logic [11:0] out_len;
  logic [11:0] src_max;
  logic [27:0] step;
  logic [27:0] init_phase;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  alpha;
  logic [11:0] src_idx;
  logic [11:0] src_adv;
  logic        out_last;
  logic        busy;
  logic        done;

  int tests;
  int fails;
  int ei[8];
  int ea[8];
  int ed[8];

  dc_ipu_filter_phase_gen dut (
    .clk        (clk),
    .nreset     (nreset),
    .start      (start),
    .out_len    (out_len),
    .src_max    (src_max),
    .step       (step),
    .init_phase (init_phase),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alpha      (alpha),
    .src_idx    (src_idx),
    .src_adv    (src_adv),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_line(input string name,
                          input int n,
                          input int smax,
                          input logic [27:0] st,
                          input logic [27:0] ip,
                          input int stall_at);
    out_len    = 12'(n);
    src_max    = 12'(smax);
    step       = st;
    init_phase = ip;
    out_ready  = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k == stall_at) begin
        out_ready = 1'b0;
        start     = 1'b1;
        out_len   = 12'd0;
        for (int s = 0; s < 3; s++) begin
          tick();
          check({name, " stall_valid"}, 32'(out_valid), 32'd1);
          check({name, " stall_idx"}, 32'(src_idx), 32'(ei[k]));
          check({name, " stall_alpha"}, 32'(alpha), 32'(ea[k]));
        end
        start     = 1'b0;
        out_ready = 1'b1;
      end
      check($sformatf("%s valid%0d", name, k), 32'(out_valid), 32'd1);
      check($sformatf("%s idx%0d", name, k), 32'(src_idx), 32'(ei[k]));
      check($sformatf("%s alpha%0d", name, k), 32'(alpha), 32'(ea[k]));
      check($sformatf("%s adv%0d", name, k), 32'(src_adv), 32'(ed[k]));
      check($sformatf("%s last%0d", name, k), 32'(out_last),
            32'(k == n - 1));
      check($sformatf("%s busy%0d", name, k), 32'(busy), 32'd1);
      check($sformatf("%s done%0d", name, k), 32'(done), 32'd0);
      tick();
    end
    check({name, " done"}, 32'(done), 32'd1);
    check({name, " done_busy"}, 32'(busy), 32'd1);
    check({name, " done_valid"}, 32'(out_valid), 32'd0);
    tick();
    check({name, " idle_done"}, 32'(done), 32'd0);
    check({name, " idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    nreset     = 1'b0;
    start      = 1'b0;
    out_len    = '0;
    src_max    = '0;
    step       = '0;
    init_phase = '0;
    out_ready  = 1'b0;
    tick();
    tick();
    check("rst valid", 32'(out_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst last", 32'(out_last), 32'd0);
    check("rst idx", 32'(src_idx), 32'd0);
    check("rst alpha", 32'(alpha), 32'd0);
    check("rst adv", 32'(src_adv), 32'd0);
    nreset = 1'b1;
    tick();

    ei = '{0, 1, 2, 3, 0, 0, 0, 0};
    ea = '{0, 0, 0, 0, 0, 0, 0, 0};
    ed = '{0, 1, 1, 1, 0, 0, 0, 0};
    run_line("ident", 4, 100, 28'h0010000, 28'h0, -1);

    ei = '{0, 0, 1, 1, 0, 0, 0, 0};
    ea = '{0, 128, 0, 128, 0, 0, 0, 0};
    ed = '{0, 0, 1, 0, 0, 0, 0, 0};
    run_line("up2", 4, 100, 28'h0008000, 28'h0, -1);
    run_line("stall", 4, 100, 28'h0008000, 28'h0, 1);

    ei = '{0, 1, 2, 2, 2, 0, 0, 0};
    ea = '{0, 0, 0, 0, 0, 0, 0, 0};
    ed = '{0, 1, 1, 0, 0, 0, 0, 0};
    run_line("clamp", 5, 2, 28'h0010000, 28'h0, -1);

    ei = '{0, 1, 1, 0, 0, 0, 0, 0};
    ea = '{0, 128, 0, 0, 0, 0, 0, 0};
    ed = '{0, 1, 0, 0, 0, 0, 0, 0};
    run_line("clampa", 3, 1, 28'h0018000, 28'h0, -1);

    ei = '{1, 1, 2, 0, 0, 0, 0, 0};
    ea = '{128, 192, 0, 0, 0, 0, 0, 0};
    ed = '{0, 0, 1, 0, 0, 0, 0, 0};
    run_line("init", 3, 10, 28'h0004000, 28'h0018000, -1);

    ei = '{3, 3, 3, 0, 0, 0, 0, 0};
    ea = '{64, 64, 64, 0, 0, 0, 0, 0};
    ed = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_line("step0", 3, 10, 28'h0, 28'h0034000, -1);

`ifdef DC_IPU_PHASE_ROUND_EN
    ei = '{0, 1, 0, 0, 0, 0, 0, 0};
    ea = '{0, 0, 0, 0, 0, 0, 0, 0};
    ed = '{0, 1, 0, 0, 0, 0, 0, 0};
`else
    ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    ea = '{0, 255, 0, 0, 0, 0, 0, 0};
    ed = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
    run_line("round", 2, 100, 28'h000FF80, 28'h0, -1);

    out_len = 12'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check("zero busy", 32'(busy), 32'd1);
    check("zero done", 32'(done), 32'd1);
    check("zero valid", 32'(out_valid), 32'd0);
    tick();
    check("zero busy2", 32'(busy), 32'd0);
    check("zero done2", 32'(done), 32'd0);
    check("zero valid2", 32'(out_valid), 32'd0);

    out_len    = 12'd6;
    src_max    = 12'd100;
    step       = 28'h0018000;
    init_phase = 28'h0;
    out_ready  = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mid idx", 32'(src_idx), 32'd1);
    check("mid alpha", 32'(alpha), 32'd128);
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    check("rr valid", 32'(out_valid), 32'd0);
    check("rr busy", 32'(busy), 32'd0);
    check("rr done", 32'(done), 32'd0);
    check("rr last", 32'(out_last), 32'd0);
    check("rr idx", 32'(src_idx), 32'd0);
    check("rr alpha", 32'(alpha), 32'd0);
    check("rr adv", 32'(src_adv), 32'd0);
    tick();
    check("rr done2", 32'(done), 32'd0);
    check("rr valid2", 32'(out_valid), 32'd0);

    ei = '{0, 1, 2, 3, 0, 0, 0, 0};
    ea = '{0, 0, 0, 0, 0, 0, 0, 0};
    ed = '{0, 1, 1, 1, 0, 0, 0, 0};
    run_line("after", 4, 100, 28'h0010000, 28'h0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
